// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit packetizer: FSM states, PID codes, CRC16 constants
// and the byte-wide reflected CRC16 update used by usb_crc16.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PID  = 3'd1,
        ST_DATA = 3'd2,
        ST_CRC1 = 3'd3,
        ST_CRC2 = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    localparam logic [3:0]  PID_DATA0    = 4'h3;
    localparam logic [3:0]  PID_DATA1    = 4'hB;
    localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY_R = 16'hA001;

    // LSB-first byte update of the reflected USB CRC16
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data_in);
        logic [15:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if ((c[0] ^ data_in[i]) == 1'b1) begin
                c = (c >> 1) ^ CRC16_POLY_R;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-wide USB CRC16 register: clear reloads the init value, enable folds one byte in.
// Only instantiated when USB_TX_CRC16_EN is defined.
module usb_crc16
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;

    // CRC accumulator; clear has priority over a same-cycle enable
    always_ff @(posedge clk) begin
        if (!reset) begin
            crc_q <= CRC16_INIT;
        end else if (clear_i) begin
            crc_q <= CRC16_INIT;
        end else if (en_i) begin
            crc_q <= crc16_byte(crc_q, data_i);
        end else begin
            crc_q <= crc_q;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/usb_tx_packetizer.sv
// USB-style transmit packet sequencer: PID, N payload bytes, optional CRC16 over a valid/ready stream.
// Define USB_TX_CRC16_EN to append the inverted CRC16 (low byte first) after the payload.
module usb_tx_packetizer
    import usb_tx_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 64,
    parameter int HIST_W  = 10,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              send_data,
    input  logic [3:0]        pid,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic [HIST_W-1:0] hist
);

    state_e             state_q;
    logic [3:0]         pid_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [HIST_W-1:0]  hist_q;
    logic               beat_s;
    logic               tx_valid_s;
    logic [DATA_W-1:0]  tx_data_s;
    logic               in_ready_s;
    logic [LEN_W-1:0]   len_sat_s;

    assign beat_s    = tx_valid_s & tx_ready;
    assign len_sat_s = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;

`ifdef USB_TX_CRC16_EN
    logic [15:0] crc_s;

    usb_crc16 u_crc (
        .clk     (clk),
        .reset   (reset),
        .clear_i ((state_q == ST_IDLE) && send_data),
        .en_i    ((state_q == ST_DATA) && beat_s),
        .data_i  (in_data[7:0]),
        .crc_o   (crc_s)
    );
`endif

    // Packet sequencer; done/busy are registered alongside the state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pid_q   <= 4'h0;
            len_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (send_data) begin
                        state_q <= ST_PID;
                        pid_q   <= pid;
                        len_q   <= len_sat_s;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_PID: begin
                    if (beat_s) begin
                        if (len_q != '0) begin
                            state_q <= ST_DATA;
                        end else begin
`ifdef USB_TX_CRC16_EN
                            state_q <= ST_CRC1;
`else
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
`endif
                        end
                    end
                end
                ST_DATA: begin
                    if (beat_s) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (cnt_q == len_q - LEN_W'(1)) begin
`ifdef USB_TX_CRC16_EN
                            state_q <= ST_CRC1;
`else
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef USB_TX_CRC16_EN
                ST_CRC1: begin
                    if (beat_s) begin
                        state_q <= ST_CRC2;
                    end
                end
                ST_CRC2: begin
                    if (beat_s) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Beat history, runs in every state
    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= {hist_q[HIST_W-2:0], beat_s};
        end
    end

    // Stream outputs decoded straight from the state so a byte can go out in the cycle it is offered
    always_comb begin
        tx_valid_s = 1'b0;
        tx_data_s  = '0;
        in_ready_s = 1'b0;
        case (state_q)
            ST_PID: begin
                tx_valid_s = 1'b1;
                tx_data_s  = DATA_W'({~pid_q, pid_q});
            end
            ST_DATA: begin
                tx_valid_s = in_valid;
                tx_data_s  = in_data;
                in_ready_s = tx_ready;
            end
`ifdef USB_TX_CRC16_EN
            ST_CRC1: begin
                tx_valid_s = 1'b1;
                tx_data_s  = DATA_W'(~crc_s[7:0]);
            end
            ST_CRC2: begin
                tx_valid_s = 1'b1;
                tx_data_s  = DATA_W'(~crc_s[15:8]);
            end
`endif
            default: begin
                tx_valid_s = 1'b0;
                tx_data_s  = '0;
                in_ready_s = 1'b0;
            end
        endcase
    end

    assign tx_valid = tx_valid_s;
    assign tx_data  = tx_data_s;
    assign in_ready = in_ready_s;
    assign busy     = busy_q;
    assign done     = done_q;
    assign hist     = hist_q;

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// Directed bench for usb_tx_packetizer; expected CRC bytes appear only when USB_TX_CRC16_EN is defined.
module tb_usb_tx_packetizer;

`ifdef USB_TX_CRC16_EN
    localparam int CRC_B = 2;
`else
    localparam int CRC_B = 0;
`endif

    logic       clk;
    logic       reset;
    logic       send_data;
    logic [3:0] pid;
    logic [6:0] len;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic [9:0] hist;

    usb_tx_packetizer #(.DATA_W(8), .MAX_LEN(64), .HIST_W(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .send_data (send_data),
        .pid       (pid),
        .len       (len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done),
        .hist      (hist)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] pl[$];
    logic [7:0] got[$];
    int pidx;
    bit done_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

`ifdef USB_TX_CRC16_EN
    function automatic logic [15:0] crc_ref(input int n);
        logic [15:0] r;
        logic [7:0] b;
        r = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            b = pl[i];
            repeat (8) begin
                if (r[0] != b[0]) r = {1'b0, r[15:1]} ^ 16'hA001;
                else              r = {1'b0, r[15:1]};
                b = {1'b0, b[7:1]};
            end
        end
        return r;
    endfunction
`endif

    task automatic start(input logic [3:0] p, input logic [6:0] l);
        send_data = 1'b1;
        pid = p;
        len = l;
        in_valid = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        send_data = 1'b0;
        #1;
        chk("busy_start", busy, 1);
    endtask

    // rmode 0: tx_ready always high; 1: low for 3 cycles then high
    task automatic drain(input int rmode, input int vgap, input int pulse_at, input int plen, input int limit);
        bit held;
        logic [7:0] held_d;
        int nb;
        got.delete();
        pidx = 0;
        done_seen = 0;
        held = 0;
        held_d = 8'h00;
        nb = 0;
        for (int c = 0; c < limit; c++) begin
            tx_ready  = (rmode == 0) ? 1'b1 : ((c % 4) == 3);
            in_valid  = ((c % (vgap + 1)) == 0);
            in_data   = (pidx < pl.size()) ? pl[pidx] : 8'hEE;
            send_data = (c == pulse_at);
            #1;
            if (held) begin
                chk("hold_valid", tx_valid, 1);
                chk("hold_data", tx_data, held_d);
            end
            if (done) begin
                done_seen = 1;
                break;
            end
            held = 0;
            if (nb >= 1 && nb <= plen) chk("data_follow", tx_valid, in_valid);
            if (tx_valid && !tx_ready && (nb == 0 || nb > plen)) begin
                held = 1;
                held_d = tx_data;
            end
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
                nb++;
            end
            if (in_valid && in_ready) pidx++;
            @(negedge clk);
        end
        send_data = 1'b0;
        chk("done_seen", done_seen, 1);
    endtask

    task automatic check_pkt(input logic [3:0] p, input int plen, input bit hist_contig);
        logic [7:0] exq[$];
        int n;
`ifdef USB_TX_CRC16_EN
        logic [15:0] c;
`endif
        exq.push_back({~p, p});
        for (int i = 0; i < plen; i++) exq.push_back(pl[i]);
`ifdef USB_TX_CRC16_EN
        c = crc_ref(plen);
        exq.push_back(~c[7:0]);
        exq.push_back(~c[15:8]);
`endif
        n = 1 + plen + CRC_B;
        chk("beat_count", got.size(), n);
        chk("payload_used", pidx, plen);
        for (int i = 0; i < exq.size() && i < got.size(); i++) chk("beat_byte", got[i], exq[i]);
        chk("busy_done", busy, 1);
        chk("txv_done", tx_valid, 0);
        if (hist_contig) chk("hist_done", hist, (10'd1 << n) - 10'd1);
        @(negedge clk);
        #1;
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
        chk("txv_idle", tx_valid, 0);
    endtask

    initial begin
        reset = 1'b0;
        send_data = 1'b0;
        pid = 4'h0;
        len = 7'd0;
        in_data = 8'h00;
        in_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_txv", tx_valid, 0);
        chk("rst_inr", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_txd", tx_data, 0);
        chk("rst_hist", hist, 0);
        reset = 1'b1;
        @(negedge clk);
        #1;

        // Zero-length packet
        pl.delete();
        start(4'h3, 7'd0);
        drain(0, 0, -1, 0, 20);
        check_pkt(4'h3, 0, 1);

        // Four payload bytes, back to back, after the history has drained
        repeat (12) @(negedge clk);
        #1;
        pl.delete();
        for (int i = 0; i < 4; i++) pl.push_back(8'(i));
        start(4'hB, 7'd4);
        drain(0, 0, -1, 4, 30);
        check_pkt(4'hB, 4, 1);

        // Immediate restart in the IDLE cycle, with PHY stalls
        pl.delete();
        pl.push_back(8'hA5); pl.push_back(8'h5A); pl.push_back(8'hFF);
        start(4'h3, 7'd3);
        drain(1, 0, -1, 3, 80);
        check_pkt(4'h3, 3, 0);

        // Source gaps
        pl.delete();
        for (int i = 0; i < 5; i++) pl.push_back(8'(8'h10 + 8'(i * 17)));
        start(4'hB, 7'd5);
        drain(0, 1, -1, 5, 40);
        check_pkt(4'hB, 5, 0);

        // Oversized length saturates, and send_data while busy is ignored
        pl.delete();
        for (int i = 0; i < 70; i++) pl.push_back(8'(i * 3 + 1));
        start(4'h3, 7'h7F);
        drain(0, 0, 10, 64, 200);
        check_pkt(4'h3, 64, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("no_requeue", busy, 0);

        // Reset in the middle of the payload
        pl.delete();
        start(4'hB, 7'd5);
        tx_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h55;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_busy", busy, 1);
        chk("mid_inr", in_ready, 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_txv", tx_valid, 0);
        chk("abort_hist", hist, 0);
        chk("abort_done", done, 0);
        chk("abort_inr", in_ready, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("abort_quiet_done", done, 0);
            chk("abort_quiet_txv", tx_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
